// File: rtl/rf_ctrl_pkg.sv
// Shared opcode and state encodings plus default widths for the register-file controller.
package rf_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned OP_W       = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/rf_ctrl_if.sv
// Command bus plus register-file side signals of the controller.
interface rf_ctrl_if
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [DATA_W-1:0] cmd_imm;

    logic              w;
    logic [ADDR_W-1:0] sw;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] sb;
    logic [DATA_W-1:0] c_in;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;

    logic              done;
    logic [DATA_W-1:0] res_data;
    logic              flag_c;
    logic              flag_z;

    // Controller view
    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  a_out, b_out,
        output cmd_ready, w, sw, sa, sb, c_in, done, res_data, flag_c, flag_z
    );

    // Command issuer / register-file view
    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output a_out, b_out,
        input  cmd_ready, w, sw, sa, sb, c_in, done, res_data, flag_c, flag_z
    );

endinterface

// File: rtl/alu8.sv
// Combinational datapath: result, carry/borrow and zero for every opcode.
module alu8
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z
);

    logic [DATA_W:0] sum;

    // Extended-width add/sub so the top bit is carry (ADD) or borrow (SUB)
    always_comb begin
        sum    = '0;
        result = '0;
        c      = 1'b0;
        case (op)
            OP_LDI: result = imm;
            OP_MOV: result = a;
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
            end
            OP_SUB: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
            end
            default: result = '0;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/fichero_reg.sv
// Register file: synchronous write, registered read (data one clock after select).
module fichero_reg
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              w,
    input  logic [ADDR_W-1:0] sw,
    input  logic [ADDR_W-1:0] sa,
    input  logic [ADDR_W-1:0] sb,
    input  logic [DATA_W-1:0] c_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Storage array and read ports; no reset on the array itself
    always_ff @(posedge clk) begin
        if (w) begin
            regs[sw] <= c_in;
        end
        a_out <= regs[sa];
        b_out <= regs[sb];
    end

endmodule

// File: rtl/rf_ctrl.sv
// Register-file controller: accepts LDI/MOV/ADD/SUB commands and sequences
// read, execute and write against an external register file.
module rf_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    rf_ctrl_if.slave   bus
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] sw_q, sw_d;
    logic [ADDR_W-1:0] sa_q, sa_d;
    logic [ADDR_W-1:0] sb_q, sb_d;
    logic [DATA_W-1:0] c_in_q, c_in_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              fc_q, fc_d;
    logic              fz_q, fz_d;
    logic              w_q, w_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    op_e               alu_op_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              alu_cy_c;
    logic              alu_z_c;

    // LDI is resolved at acceptance from the live command; others use the latched opcode
    assign alu_op_c = (state_q == IDLE) ? op_e'(bus.cmd_op) : op_q;

    alu8 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (alu_op_c),
        .a      (bus.a_out),
        .b      (bus.b_out),
        .imm    (bus.cmd_imm),
        .result (alu_res_c),
        .c      (alu_cy_c),
        .z      (alu_z_c)
    );

    // Next-state and next-output logic; selects hold unless reloaded
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        sw_d    = sw_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        c_in_d  = c_in_q;
        res_d   = res_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        w_d     = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d  = op_e'(bus.cmd_op);
                    dst_d = bus.cmd_dst;
                    if (op_e'(bus.cmd_op) == OP_LDI) begin
                        state_d = WRITE;
                        w_d     = 1'b1;
                        done_d  = 1'b1;
                        sw_d    = bus.cmd_dst;
                        c_in_d  = alu_res_c;
                        res_d   = alu_res_c;
                        fc_d    = alu_cy_c;
                        fz_d    = alu_z_c;
                    end else begin
                        state_d = READ;
                        sa_d    = bus.cmd_src_a;
                        sb_d    = bus.cmd_src_b;
                    end
                end
            end
            READ: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = WRITE;
                w_d     = 1'b1;
                done_d  = 1'b1;
                sw_d    = dst_q;
                c_in_d  = alu_res_c;
                res_d   = alu_res_c;
                fc_d    = alu_cy_c;
                fz_d    = alu_z_c;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LDI;
            dst_q   <= '0;
            sw_q    <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            c_in_q  <= '0;
            res_q   <= '0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            sw_q    <= sw_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            c_in_q  <= c_in_d;
            res_q   <= res_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            w_q     <= w_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.w         = w_q;
    assign bus.sw        = sw_q;
    assign bus.sa        = sa_q;
    assign bus.sb        = sb_q;
    assign bus.c_in      = c_in_q;
    assign bus.done      = done_q;
    assign bus.res_data  = res_q;
    assign bus.flag_c    = fc_q;
    assign bus.flag_z    = fz_q;

endmodule

// File: tb/tb_rf_ctrl.sv
// Scoreboard bench: rf_ctrl paired with fichero_reg, expected writes queued at issue.
module tb_rf_ctrl;
    import rf_ctrl_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    typedef struct {
        logic [2:0] dst;
        logic [7:0] data;
        logic       c;
        logic       z;
        int         acc;
        int         lat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   acc_cyc = 0;
    int   acc_lat = 0;
    exp_t sb_q[$];
    logic [7:0] rf_m [8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rf_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fichero_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clk   (clk),
        .w     (bus.w),
        .sw    (bus.sw),
        .sa    (bus.sa),
        .sb    (bus.sb),
        .c_in  (bus.c_in),
        .a_out (bus.a_out),
        .b_out (bus.b_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Observes every write pulse and handshake timing on the falling edge
    task automatic monitor();
        exp_t e;
        logic prev_w;
        prev_w = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.w || bus.done) begin
                    n_done++;
                    check("w_eq_done", 32'(bus.w), 32'(bus.done));
                    check("w_one_cycle", 32'(prev_w), 32'd0);
                    check("ready_in_write", 32'(bus.cmd_ready), 32'd0);
                    check("write_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sw", 32'(bus.sw), 32'(e.dst));
                        check("c_in", 32'(bus.c_in), 32'(e.data));
                        check("res_data", 32'(bus.res_data), 32'(e.data));
                        check("flag_c", 32'(bus.flag_c), 32'(e.c));
                        check("flag_z", 32'(bus.flag_z), 32'(e.z));
                        check("latency", 32'(cyc - e.acc), 32'(e.lat - 1));
                    end
                end
                if (acc_lat != 0 && cyc >= acc_cyc && cyc < acc_cyc + acc_lat)
                    check("ready_busy", 32'(bus.cmd_ready), 32'd0);
                else if (acc_lat != 0 && cyc == acc_cyc + acc_lat)
                    check("ready_after", 32'(bus.cmd_ready), 32'd1);
                prev_w = bus.w;
            end else begin
                prev_w = 1'b0;
            end
        end
    endtask

    // Drive one command, wait for acceptance, queue the model's expected write
    task automatic send(input logic [1:0] op, input int dst, input int a, input int b,
                        input logic [7:0] imm);
        exp_t e;
        logic [8:0] s;
        int g;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = 3'(dst);
        bus.cmd_src_a = 3'(a);
        bus.cmd_src_b = 3'(b);
        bus.cmd_imm   = imm;
        g = 0;
        while (bus.cmd_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("accept", 32'(bus.cmd_ready), 32'd1);
        e.c = 1'b0;
        case (op)
            2'b00: e.data = imm;
            2'b01: e.data = rf_m[3'(a)];
            2'b10: begin
                s      = {1'b0, rf_m[3'(a)]} + {1'b0, rf_m[3'(b)]};
                e.data = s[7:0];
                e.c    = s[8];
            end
            default: begin
                e.data = rf_m[3'(a)] - rf_m[3'(b)];
                e.c    = (rf_m[3'(a)] < rf_m[3'(b)]);
            end
        endcase
        e.z   = (e.data == 8'd0);
        e.dst = 3'(dst);
        e.acc = cyc + 1;
        e.lat = (op == 2'b00) ? 1 : 3;
        sb_q.push_back(e);
        rf_m[3'(dst)] = e.data;
        acc_cyc = e.acc;
        acc_lat = e.lat;
        @(posedge clk);
    endtask

    // Drop valid and scramble the command fields after acceptance
    task automatic release_cmd();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_dst   = 3'($urandom);
        bus.cmd_src_a = 3'($urandom);
        bus.cmd_src_b = 3'($urandom);
        bus.cmd_imm   = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w"},      32'(bus.w), 32'd0);
        check({tag, "_done"},   32'(bus.done), 32'd0);
        check({tag, "_sw"},     32'(bus.sw), 32'd0);
        check({tag, "_sa"},     32'(bus.sa), 32'd0);
        check({tag, "_sb"},     32'(bus.sb), 32'd0);
        check({tag, "_c_in"},   32'(bus.c_in), 32'd0);
        check({tag, "_res"},    32'(bus.res_data), 32'd0);
        check({tag, "_flag_c"}, 32'(bus.flag_c), 32'd0);
        check({tag, "_flag_z"}, 32'(bus.flag_z), 32'd0);
        check({tag, "_ready"},  32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_tests();
        int d0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_dst   = '0;
        bus.cmd_src_a = '0;
        bus.cmd_src_b = '0;
        bus.cmd_imm   = '0;
        for (int i = 0; i < 8; i++) rf_m[i] = 8'd0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check("ready_post_rst", 32'(bus.cmd_ready), 32'd1);

        // Load r_i = i*3, then read each back with MOV
        d0 = n_done;
        for (int i = 0; i < 8; i++) send(2'b00, i, 0, 0, 8'(i * 3));
        release_cmd();
        drain();
        check("ldi_done_cnt", 32'(n_done - d0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            send(2'b01, i, i, 0, 8'd0);
            release_cmd();
            drain();
            check("mov_rb", 32'(bus.res_data), 32'(i * 3));
        end

        // ADD with carry out
        send(2'b00, 1, 0, 0, 8'd200);
        send(2'b00, 2, 0, 0, 8'd100);
        send(2'b10, 3, 1, 2, 8'd0);
        release_cmd();
        drain();
        check("add_res", 32'(bus.res_data), 32'd44);
        check("add_c", 32'(bus.flag_c), 32'd1);
        check("add_z", 32'(bus.flag_z), 32'd0);
        send(2'b01, 3, 3, 0, 8'd0);
        release_cmd();
        drain();
        check("r3_rb", 32'(bus.res_data), 32'd44);

        // SUB to zero, then SUB with borrow
        send(2'b00, 4, 0, 0, 8'd5);
        send(2'b11, 5, 4, 4, 8'd0);
        release_cmd();
        drain();
        check("sub0_res", 32'(bus.res_data), 32'd0);
        check("sub0_z", 32'(bus.flag_z), 32'd1);
        check("sub0_c", 32'(bus.flag_c), 32'd0);
        send(2'b11, 6, 0, 4, 8'd0);
        release_cmd();
        drain();
        check("subb_res", 32'(bus.res_data), 32'd251);
        check("subb_c", 32'(bus.flag_c), 32'd1);
        check("subb_z", 32'(bus.flag_z), 32'd0);

        // Back-to-back RAW with valid held high
        send(2'b00, 7, 0, 0, 8'd9);
        send(2'b10, 7, 7, 7, 8'd0);
        release_cmd();
        drain();
        check("raw_res", 32'(bus.res_data), 32'd18);
        send(2'b01, 7, 7, 0, 8'd0);
        release_cmd();
        drain();
        check("r7_rb", 32'(bus.res_data), 32'd18);

        // Reset during EXEC aborts the ADD
        send(2'b00, 3, 0, 0, 8'd77);
        release_cmd();
        drain();
        send(2'b10, 3, 1, 2, 8'd0);
        release_cmd();
        acc_lat = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_outputs("abort");
        sb_q.delete();
        rf_m[3] = 8'd77;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(bus.cmd_ready), 32'd1);
        send(2'b01, 3, 3, 0, 8'd0);
        release_cmd();
        drain();
        check("r3_kept", 32'(bus.res_data), 32'd77);
        send(2'b00, 0, 0, 0, 8'd1);
        release_cmd();
        drain();
        send(2'b01, 0, 0, 0, 8'd0);
        release_cmd();
        drain();
        check("r0_after", 32'(bus.res_data), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
